// File: rtl/writeback_queue_if.sv
// rtl/writeback_queue_if.sv - enqueue, register-file write and bypass signals of the writeback queue
interface writeback_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int CW = $clog2(DEPTH) + 1;

    // load-unit enqueue port
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    // ALU enqueue port
    logic              alu_valid;
    logic              alu_link;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    // register-file write port
    logic              rf_ready;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    // operand bypass lookup
    logic [ADDR_W-1:0] byp_addr;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;

    logic [CW-1:0]     count;

    modport master (
        output mem_valid, mem_addr, mem_data,
        output alu_valid, alu_link, alu_addr, alu_data,
        output rf_ready, byp_addr,
        input  mem_ready, alu_ready, wb_en, wb_addr, wb_data,
        input  byp_hit, byp_data, count
    );

    modport slave (
        input  mem_valid, mem_addr, mem_data,
        input  alu_valid, alu_link, alu_addr, alu_data,
        input  rf_ready, byp_addr,
        output mem_ready, alu_ready, wb_en, wb_addr, wb_data,
        output byp_hit, byp_data, count
    );
endinterface

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - in-order register-file writeback queue with two enqueue ports and operand bypass
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    writeback_queue_if.slave   wq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0]     FULL     = CW'(DEPTH);
    localparam logic [CW-1:0]     ALMOST   = CW'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LINK_REG = ADDR_W'(31);

    // entry storage; vld_q marks slots holding a not-yet-written result
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;

    logic              mem_rdy;
    logic              alu_rdy;
    logic              mem_acc;
    logic              alu_acc;
    logic              deq;
    logic [PW-1:0]     alu_slot;
    logic [ADDR_W-1:0] alu_tgt;

    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic [PW-1:0]     scan_idx;

    // acceptance uses the registered count only, so a same-cycle retire never
    // frees space early; the load unit keeps priority for the last slot
    always_comb begin
        mem_rdy  = cnt < FULL;
        alu_rdy  = (cnt < ALMOST) || ((cnt < FULL) && !wq.mem_valid);
        mem_acc  = wq.mem_valid && mem_rdy;
        alu_acc  = wq.alu_valid && alu_rdy;
        deq      = (cnt != '0) && wq.rf_ready;
        alu_slot = mem_acc ? (wr_ptr + PW'(1)) : wr_ptr;
        alu_tgt  = wq.alu_link ? LINK_REG : wq.alu_addr;
    end

    // entry writes; the load result is older than a same-cycle ALU result
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (deq) begin
                vld_q[rd_ptr] <= 1'b0;
            end
            if (mem_acc) begin
                addr_q[wr_ptr] <= wq.mem_addr;
                data_q[wr_ptr] <= wq.mem_data;
                vld_q[wr_ptr]  <= 1'b1;
            end
            if (alu_acc) begin
                addr_q[alu_slot] <= alu_tgt;
                data_q[alu_slot] <= wq.alu_data;
                vld_q[alu_slot]  <= 1'b1;
            end
        end
    end

    // pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(mem_acc) + PW'(alu_acc);
            rd_ptr <= rd_ptr + PW'(deq);
            cnt    <= cnt + CW'(mem_acc) + CW'(alu_acc) - CW'(deq);
        end
    end

    // bypass scan from head towards tail so the youngest match wins; the
    // retiring head stays visible and same-cycle enqueues are not yet stored
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr + PW'(i);
            if (vld_q[scan_idx] && (addr_q[scan_idx] == wq.byp_addr)) begin
                hit      = 1'b1;
                hit_data = data_q[scan_idx];
            end
        end
    end

    assign wq.mem_ready = mem_rdy;
    assign wq.alu_ready = alu_rdy;
    assign wq.count     = cnt;
    assign wq.wb_en     = (cnt != '0);
    assign wq.wb_addr   = (cnt != '0) ? addr_q[rd_ptr] : '0;
    assign wq.wb_data   = (cnt != '0) ? data_q[rd_ptr] : '0;
    assign wq.byp_hit   = hit;
    assign wq.byp_data  = hit_data;

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - randomized scoreboard bench for writeback_queue
module tb_writeback_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_fail;

    ent_t mq[$];
    ent_t sb[$];

    writeback_queue_if #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) bus ();

    writeback_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .wq    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: a plain list of pending writes, evaluated at negedge
    always @(negedge clock) begin : model
        int   n;
        int   exp_cnt;
        logic exp_mr;
        logic exp_ar;
        logic exp_hit;
        logic [31:0] exp_bd;
        ent_t e;
        if (!reset) begin
            check("rst_count", 64'(bus.count), 64'd0);
            check("rst_wb_en", 64'(bus.wb_en), 64'd0);
            check("rst_wb_addr", 64'(bus.wb_addr), 64'd0);
            check("rst_wb_data", 64'(bus.wb_data), 64'd0);
            check("rst_byp_hit", 64'(bus.byp_hit), 64'd0);
            check("rst_byp_data", 64'(bus.byp_data), 64'd0);
            check("rst_mem_ready", 64'(bus.mem_ready), 64'd1);
            check("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
            mq.delete();
            sb.delete();
        end else begin
            n       = mq.size();
            exp_cnt = n;
            exp_mr  = (n < DEPTH);
            exp_ar  = (n < DEPTH - 1) || ((n < DEPTH) && !bus.mem_valid);
            check("count", 64'(bus.count), 64'(exp_cnt));
            check("mem_ready", 64'(bus.mem_ready), 64'(exp_mr));
            check("alu_ready", 64'(bus.alu_ready), 64'(exp_ar));
            check("wb_en", 64'(bus.wb_en), 64'(n != 0));
            if (n != 0) begin
                check("wb_addr", 64'(bus.wb_addr), 64'(mq[0].a));
                check("wb_data", 64'(bus.wb_data), 64'(mq[0].d));
            end else begin
                check("wb_addr_idle", 64'(bus.wb_addr), 64'd0);
                check("wb_data_idle", 64'(bus.wb_data), 64'd0);
            end
            exp_hit = 1'b0;
            exp_bd  = '0;
            for (int i = n - 1; i >= 0; i--) begin
                if (!exp_hit && mq[i].a == bus.byp_addr) begin
                    exp_hit = 1'b1;
                    exp_bd  = mq[i].d;
                end
            end
            check("byp_hit", 64'(bus.byp_hit), 64'(exp_hit));
            check("byp_data", 64'(bus.byp_data), 64'(exp_bd));
            if (n != 0 && bus.rf_ready) void'(mq.pop_front());
            if (bus.mem_valid && exp_mr) begin
                e = '{a: bus.mem_addr, d: bus.mem_data};
                mq.push_back(e);
                sb.push_back(e);
            end
            if (bus.alu_valid && exp_ar) begin
                e = '{a: (bus.alu_link ? 5'd31 : bus.alu_addr), d: bus.alu_data};
                mq.push_back(e);
                sb.push_back(e);
            end
        end
    end

    // monitor: every register-file write must match the next expected entry
    always @(negedge clock) begin : monitor
        ent_t e;
        if (reset && bus.wb_en && bus.rf_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL wb_order: got write %0h<=%0h expected no write at %0t",
                         bus.wb_addr, bus.wb_data, $time);
            end else begin
                e = sb.pop_front();
                check("wb_order_addr", 64'(bus.wb_addr), 64'(e.a));
                check("wb_order_data", 64'(bus.wb_data), 64'(e.d));
            end
        end
    end

    task automatic drive(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic av, input logic al, input logic [4:0] aa,
                         input logic [31:0] ad, input logic rr, input logic [4:0] ba);
        bus.mem_valid = mv;
        bus.mem_addr  = ma;
        bus.mem_data  = md;
        bus.alu_valid = av;
        bus.alu_link  = al;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
        bus.rf_ready  = rr;
        bus.byp_addr  = ba;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic rr, input logic [4:0] ba);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, rr, ba);
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("async_wb_en", 64'(bus.wb_en), 64'd0);
        check("async_count", 64'(bus.count), 64'd0);
        check("async_byp_hit", 64'(bus.byp_hit), 64'd0);
        @(posedge clock);
        @(posedge clock);
        #3;
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        reset  = 1'b1;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_data  = '0;
        bus.alu_valid = 1'b0;
        bus.alu_link  = 1'b0;
        bus.alu_addr  = '0;
        bus.alu_data  = '0;
        bus.rf_ready  = 1'b0;
        bus.byp_addr  = '0;
        #2 reset = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #3 reset = 1'b1;
        @(posedge clock);
        #1;

        // 1: single ALU write drains next cycle
        drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd5, 32'h0000_00AA, 1'b1, 5'd5);
        idle(1'b1, 5'd5);
        idle(1'b1, 5'd5);

        // 2: load and ALU to the same register, youngest wins the bypass
        drive(1'b1, 5'd3, 32'h11, 1'b1, 1'b0, 5'd3, 32'h22, 1'b0, 5'd3);
        idle(1'b0, 5'd3);
        idle(1'b1, 5'd3);
        idle(1'b1, 5'd3);
        idle(1'b1, 5'd3);

        // 3: link write lands in register 31
        drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd31);
        idle(1'b0, 5'd31);
        idle(1'b0, 5'd7);
        idle(1'b1, 5'd7);

        // 4: fill to full, contend at count 3, then drain and refill across the wrap
        drive(1'b1, 5'd1, 32'h101, 1'b1, 1'b0, 5'd2, 32'h102, 1'b0, 5'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd4, 32'h104, 1'b0, 5'd2);
        drive(1'b1, 5'd6, 32'h106, 1'b1, 1'b0, 5'd8, 32'h108, 1'b0, 5'd6);
        drive(1'b1, 5'd9, 32'h109, 1'b1, 1'b0, 5'd10, 32'h10A, 1'b0, 5'd9);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'(i + 11), 32'h200 + 32'(i), 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 11));
        end
        for (int i = 0; i < 6; i++) idle(1'b1, 5'd12);

        // 5: reset mid-drain discards queued entries
        drive(1'b1, 5'd20, 32'h300, 1'b1, 1'b0, 5'd21, 32'h301, 1'b0, 5'd20);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd22, 32'h302, 1'b0, 5'd20);
        idle(1'b1, 5'd20);
        pulse_reset();
        for (int i = 0; i < 3; i++) idle(1'b1, 5'd21);

        // 6: steady occupancy with simultaneous enqueue and retire, then random rf_ready
        drive(1'b1, 5'd1, 32'h401, 1'b1, 1'b0, 5'd2, 32'h402, 1'b0, 5'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd3, 32'h403, 1'b1, 5'd2);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'($urandom_range(0, 1)), 1'b0, 5'($urandom_range(0, 7)),
                  $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
        end

        // random traffic over a small register set so bypass hits are frequent
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                  5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 7)));
            if (i == 200) pulse_reset();
        end
        for (int i = 0; i < 8; i++) idle(1'b1, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Buffers register-file write requests from the ALU (single-cycle) and load unit (multi-cycle) path of the KGP-RISC datapath.
- Drains them in order, one per cycle, onto the register file's write port.
- Also provides a combinational bypass lookup so operand read logic can pick up values that are queued but not yet written.

Parameters:
DEPTH, 4, queue entries (power of two, ≥2)
DATA_W, 32, register data width
ADDR_W, 5, register address width (32 registers)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
mem_valid  input  1  load-unit result present
mem_addr  input  ADDR_W  load destination register
mem_data  input  DATA_W  load result
mem_ready  output  1  queue can accept load result this cycle
alu_valid  input  1  ALU result present
alu_link  input  1  ALU result is a link write; target forced to register 31, alu_addr ignored
alu_addr  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
alu_ready  output  1  queue can accept ALU result this cycle
rf_ready  input  1  register file accepts a write this cycle
wb_en  output  1  head entry valid; register file write requested
wb_addr  output  ADDR_W  head entry destination (31 for link entries)
wb_data  output  DATA_W  head entry data
byp_addr  input  ADDR_W  register being read by operand fetch
byp_hit  output  1  a queued entry targets byp_addr
byp_data  output  DATA_W  data of youngest matching queued entry
count  output  log2(DEPTH)+1  occupied entries

Behaviour:
- Reset (reset low, asynchronous): count=0, read/write pointers=0, all entry-valid bits cleared. wb_en=0, wb_addr=0, wb_data=0, byp_hit=0, byp_data=0, mem_ready=1, alu_ready=1. Reset mid-drain discards every queued entry; no partial write is issued after reset asserts.
- Circular buffer of DEPTH entries. Each entry stores {addr, data}; link writes are stored with addr=31 at enqueue.
- Enqueue, up to two per cycle:
  - mem accepted when mem_valid && mem_ready.
  - alu accepted when alu_valid && alu_ready.
  - Both accepted in the same cycle: mem entry written at wr_ptr, alu entry at wr_ptr+1 (mem is older).
  - Pointers wrap modulo DEPTH.
- Ready is computed from registered count only. Space freed by a same-cycle dequeue is not credited.
  - mem_ready = count<DEPTH.
  - alu_ready = count<DEPTH-1, or (count<DEPTH && !mem_valid).
  - Priority to mem: a load result cannot be replayed cheaply.
- Dequeue:
  - wb_en/wb_addr/wb_data are driven combinationally from the head entry. wb_en = count!=0.
  - When wb_en && rf_ready, the head retires at the clock edge and rd_ptr advances by 1.
  - When count==0, wb_addr and wb_data are 0.
- count_next = count + accepted_enqueues − dequeue. Simultaneous enqueue and dequeue at full: dequeue retires, enqueue was already blocked by ready.
- Bypass (combinational, same cycle):
  - Scan valid entries from youngest to oldest; the first match with addr==byp_addr sets byp_hit=1 and byp_data to that entry's data.
  - No match: byp_hit=0, byp_data=0.
  - Entries being enqueued this cycle are not visible until next cycle.
  - The head retiring this cycle is still visible this cycle.
- Write ordering to the register file is strictly enqueue order. No coalescing of same-address entries.
- Input held with valid low: no state change.

Test Plan:
1. Reset, then alu_valid with addr=5, data=0x0000_00AA, rf_ready=1 → next cycle wb_en=1, wb_addr=5, wb_data=0xAA, count=1; the following cycle count=0, wb_en=0.
2. mem_valid(addr=3, data=0x11) and alu_valid(addr=3, data=0x22) in the same cycle, rf_ready=0 → count=2; byp_addr=3 gives byp_hit=1, byp_data=0x22. Raise rf_ready → wb writes 0x11 first, then 0x22.
3. alu_link=1, alu_addr=7, data=0xDEAD_BEEF → wb_addr=31; byp_addr=31 hits; byp_addr=7 misses.
4. rf_ready=0, fill 4 entries → count=4, mem_ready=0, alu_ready=0. At count=3 with both valid: mem accepted, alu_ready=0. Raise rf_ready and drain 4 in order, with pointers wrapping correctly on refill.
5. Three queued entries, pull reset low mid-drain → wb_en=0, count=0, byp_hit=0 immediately (asynchronous). After release, no stale writes appear.
6. Simultaneous dequeue and single enqueue at count=2 → count stays 2, order preserved across 10 cycles of random rf_ready toggling, checked against a scoreboard model.
